// File: rtl/prog_lut_if.sv
// Lookup/write/clear bus of the programmable 1-bit lookup table.
// The DUT attaches through the slave modport and the requester through master.
interface prog_lut_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             valid_i;
    logic [WIDTH-1:0] x_i;
    logic             we_i;
    logic [WIDTH-1:0] waddr_i;
    logic             wdata_i;
    logic             clr_i;
    logic             valid_o;
    logic             y_o;
    logic [CNT_W-1:0] cnt_o;

    modport master (
        output valid_i, x_i, we_i, waddr_i, wdata_i, clr_i,
        input  valid_o, y_o, cnt_o
    );

    modport slave (
        input  valid_i, x_i, we_i, waddr_i, wdata_i, clr_i,
        output valid_o, y_o, cnt_o
    );
endinterface

// File: rtl/prog_lut.sv
// Programmable 1-bit lookup table with a 1-cycle registered read and an optional hit counter.
// Define PROG_LUT_HIT_CNT_EN to build the saturating hit counter; otherwise cnt_o is tied to 0.
module prog_lut #(
    parameter int unsigned                 WIDTH = 4,
    parameter logic [(2**WIDTH)-1:0]       INIT  = 16'h0510,
    parameter int unsigned                 CNT_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    prog_lut_if.slave   bus
);
    localparam int unsigned DEPTH = 2**WIDTH;

    logic [DEPTH-1:0] table_q, table_d;
    logic             y_q, y_d;
    logic             valid_q, valid_d;
    logic             rd_bit_c;

    // Read uses the pre-write table, so a same-cycle write is seen one cycle later.
    always_comb begin
        rd_bit_c = table_q[bus.x_i];
        table_d  = table_q;
        y_d      = y_q;
        valid_d  = bus.valid_i;
        if (bus.we_i) begin
            table_d[bus.waddr_i] = bus.wdata_i;
        end
        if (bus.valid_i) begin
            y_d = rd_bit_c;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            table_q <= INIT;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            table_q <= table_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.y_o     = y_q;

`ifdef PROG_LUT_HIT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear takes priority over a same-cycle hit; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_i) begin
            cnt_d = '0;
        end else if (bus.valid_i && rd_bit_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt_o = cnt_q;
`else
    logic unused_clr_c;

    assign unused_clr_c = bus.clr_i;
    assign bus.cnt_o    = '0;
`endif
endmodule

// File: tb/tb_prog_lut.sv
// Self-checking bench for prog_lut: table-driven lookups scored through a queue,
// plus directed reset and WIDTH=6 sequences.
module tb_prog_lut;
    localparam int unsigned CNT_W = 8;
    localparam int          CNT_MAX = 255;

    logic clk;
    logic rst_n;

    prog_lut_if #(.WIDTH(4), .CNT_W(CNT_W)) bus  ();
    prog_lut_if #(.WIDTH(6), .CNT_W(CNT_W)) bus6 ();

    prog_lut #(.WIDTH(4), .INIT(16'h0510), .CNT_W(CNT_W)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    prog_lut #(.WIDTH(6), .INIT(64'h8000_0000_0000_0000), .CNT_W(CNT_W)) u_dut6 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       valid;
        logic [3:0] x;
        logic       we;
        logic [3:0] waddr;
        logic       wdata;
        logic       clr;
        logic       exp_y;
    } vec_t;

    vec_t vecs[$];
    logic sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    logic hold_y   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string tag, input logic valid, input logic [3:0] x,
                                input logic we, input logic [3:0] waddr, input logic wdata,
                                input logic clr, input logic exp_y);
        vec_t v;
        v.tag = tag; v.valid = valid; v.x = x; v.we = we;
        v.waddr = waddr; v.wdata = wdata; v.clr = clr; v.exp_y = exp_y;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic e;
        @(negedge clk);
        bus.valid_i = v.valid; bus.x_i = v.x; bus.we_i = v.we;
        bus.waddr_i = v.waddr; bus.wdata_i = v.wdata; bus.clr_i = v.clr;
        if (v.valid) sb_q.push_back(v.exp_y);
`ifdef PROG_LUT_HIT_CNT_EN
        if (v.clr) exp_cnt = 0;
        else if (v.valid && v.exp_y && exp_cnt < CNT_MAX) exp_cnt++;
`endif
        @(posedge clk);
        #1;
        chk({v.tag, ".valid_o"}, 64'(bus.valid_o), 64'(v.valid));
        if (bus.valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.sb: valid_o with empty scoreboard at %0t", v.tag, $time);
            end else begin
                e = sb_q.pop_front();
                chk({v.tag, ".y_o"}, 64'(bus.y_o), 64'(e));
                hold_y = e;
            end
        end else begin
            chk({v.tag, ".y_hold"}, 64'(bus.y_o), 64'(hold_y));
        end
        chk({v.tag, ".cnt_o"}, 64'(bus.cnt_o), 64'(exp_cnt));
    endtask

    task automatic run_all();
        while (vecs.size() > 0) run_vec(vecs.pop_front());
    endtask

    initial begin
        bus.valid_i = 0; bus.x_i = '0; bus.we_i = 0; bus.waddr_i = '0; bus.wdata_i = 0; bus.clr_i = 0;
        bus6.valid_i = 0; bus6.x_i = '0; bus6.we_i = 0; bus6.waddr_i = '0; bus6.wdata_i = 0; bus6.clr_i = 0;
        rst_n = 1'b0;
        #12;
        chk("rst.valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst.y_o", 64'(bus.y_o), 64'd0);
        chk("rst.cnt_o", 64'(bus.cnt_o), 64'd0);
        chk("rst6.valid_o", 64'(bus6.valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wide table: only bit 63 set.
        @(negedge clk);
        bus6.valid_i = 1; bus6.x_i = 6'd63;
        @(posedge clk); #1;
        chk("w6_63.valid_o", 64'(bus6.valid_o), 64'd1);
        chk("w6_63.y_o", 64'(bus6.y_o), 64'd1);
        @(negedge clk);
        bus6.x_i = 6'd62;
        @(posedge clk); #1;
        chk("w6_62.y_o", 64'(bus6.y_o), 64'd0);
        @(negedge clk);
        bus6.valid_i = 0;
        @(posedge clk); #1;
        chk("w6_idle.valid_o", 64'(bus6.valid_o), 64'd0);

        // Phase A: sweep, read-vs-write ordering, hold, write without lookup.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk($sformatf("sweep%0d", i), 1, 4'(i), 0, 4'd0, 0, 0,
                              (i == 4) || (i == 8) || (i == 10)));
        vecs.push_back(mk("wr_rd_same", 1, 4'd3, 1, 4'd3, 1, 0, 0));
        vecs.push_back(mk("rd_new",     1, 4'd3, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk("idle",       0, 4'd0, 0, 4'd0, 0, 0, 0));
        vecs.push_back(mk("wr8_only",   0, 4'd0, 1, 4'd8, 0, 0, 0));
        vecs.push_back(mk("rd8_zero",   1, 4'd8, 0, 4'd0, 0, 0, 0));
        vecs.push_back(mk("rd4",        1, 4'd4, 0, 4'd0, 0, 0, 1));
        run_all();

        // Mid-stream async reset with a lookup in flight.
        @(negedge clk);
        bus.valid_i = 1; bus.x_i = 4'd4;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid_o", 64'(bus.valid_o), 64'd0);
        chk("arst.y_o", 64'(bus.y_o), 64'd0);
        chk("arst.cnt_o", 64'(bus.cnt_o), 64'd0);
        sb_q.delete();
        exp_cnt = 0;
        hold_y  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.valid_i = 0;
        @(posedge clk); #1;
        chk("post_rst.no_pulse", 64'(bus.valid_o), 64'd0);
        chk("post_rst.y_o", 64'(bus.y_o), 64'd0);

        // Phase B: restored table, counter saturation, clear priority.
        vecs.push_back(mk("rd8_init",  1, 4'd8, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk("rd3_init",  1, 4'd3, 0, 4'd0, 0, 0, 0));
        for (int i = 0; i < 300; i++)
            vecs.push_back(mk($sformatf("sat%0d", i), 1, 4'd4, 0, 4'd0, 0, 0, 1));
        vecs.push_back(mk("clr_hit",   1, 4'd4, 0, 4'd0, 0, 1, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk($sformatf("hit10_%0d", i), 1, 4'd10, 0, 4'd0, 0, 1'(i % 2), 1));
        vecs.push_back(mk("tail_idle", 0, 4'd0, 0, 4'd0, 0, 0, 0));
        run_all();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
